reg_file: RTL and testbench

- Architectural register file with per-register rename tags. Sits directly downstream of the ROB commit port and beside the decoder.
- The decoder reads operand values and dependency tags, and marks destination registers renamed to a ROB id at issue.
- The ROB writes committed results and clears matching tags.
- Flush clears all tags. Committed values persist.

---
 rtl/reg_file.sv | 99 +++++++++
 tb/tb_reg_file.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: architectural register file with per-register rename tags.
// Commit writes values and clears matching tags, rename sets tags, flush
// clears every tag. x0 always reads as value 0 / tag 0.
// Optional feature: define REG_FILE_COMMIT_BYPASS_EN to forward a same-cycle
// commit onto the read ports.
module reg_file #(
    parameter int ROB_WIDTH = 5,
    parameter int NUM_REGS  = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 commit_en,
    input  logic [4:0]           commit_reg_id,
    input  logic [31:0]          commit_data,
    input  logic [ROB_WIDTH-1:0] commit_rob_id,
    input  logic                 rename_en,
    input  logic [4:0]           rename_reg_id,
    input  logic [ROB_WIDTH-1:0] rename_rob_id,
    input  logic [4:0]           rs1_id,
    input  logic [4:0]           rs2_id,
    output logic [31:0]          rs1_value,
    output logic [ROB_WIDTH-1:0] rs1_rob_id,
    output logic [31:0]          rs2_value,
    output logic [ROB_WIDTH-1:0] rs2_rob_id
);

    logic [31:0]          r_value [NUM_REGS];
    logic [ROB_WIDTH-1:0] r_tag   [NUM_REGS];

    logic                 w_commit_fire;
    logic                 w_rename_fire;
    logic [31:0]          w_rs1_value;
    logic [ROB_WIDTH-1:0] w_rs1_rob;
    logic [31:0]          w_rs2_value;
    logic [ROB_WIDTH-1:0] w_rs2_rob;

    assign w_commit_fire = rdy_in && commit_en && (commit_reg_id != '0);
    assign w_rename_fire = rdy_in && rename_en && !flush_in && (rename_reg_id != '0);

    // State update: flush clears all tags, then commit/rename override per register.
    // Later non-blocking writes win, so rename takes priority over a commit clear.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_value <= '{default: '0};
            r_tag   <= '{default: '0};
        end else if (rdy_in) begin
            if (flush_in) begin
                r_tag <= '{default: '0};
            end
            if (w_commit_fire) begin
                r_value[commit_reg_id] <= commit_data;
                if (!flush_in && (r_tag[commit_reg_id] == commit_rob_id)) begin
                    r_tag[commit_reg_id] <= '0;
                end
            end
            if (w_rename_fire) begin
                r_tag[rename_reg_id] <= rename_rob_id;
            end
        end
    end

    // Combinational read ports, optional commit forwarding, x0 forced to zero.
    always_comb begin
        w_rs1_value = r_value[rs1_id];
        w_rs1_rob   = r_tag[rs1_id];
        w_rs2_value = r_value[rs2_id];
        w_rs2_rob   = r_tag[rs2_id];
`ifdef REG_FILE_COMMIT_BYPASS_EN
        if (w_commit_fire && (commit_reg_id == rs1_id)) begin
            w_rs1_value = commit_data;
            if (r_tag[rs1_id] == commit_rob_id) begin
                w_rs1_rob = '0;
            end
        end
        if (w_commit_fire && (commit_reg_id == rs2_id)) begin
            w_rs2_value = commit_data;
            if (r_tag[rs2_id] == commit_rob_id) begin
                w_rs2_rob = '0;
            end
        end
`endif
        if (rs1_id == '0) begin
            w_rs1_value = '0;
            w_rs1_rob   = '0;
        end
        if (rs2_id == '0) begin
            w_rs2_value = '0;
            w_rs2_rob   = '0;
        end
    end

    assign rs1_value  = w_rs1_value;
    assign rs1_rob_id = w_rs1_rob;
    assign rs2_value  = w_rs2_value;
    assign rs2_rob_id = w_rs2_rob;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed scenarios plus randomized traffic checked against an
// array-based reference model of the register file.
module tb_reg_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        commit_en;
    logic [4:0]  commit_reg_id;
    logic [31:0] commit_data;
    logic [4:0]  commit_rob_id;
    logic        rename_en;
    logic [4:0]  rename_reg_id;
    logic [4:0]  rename_rob_id;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic [31:0] rs1_value;
    logic [4:0]  rs1_rob_id;
    logic [31:0] rs2_value;
    logic [4:0]  rs2_rob_id;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [31:0] m_val [32];
    logic [4:0]  m_tag [32];

    reg_file #(.ROB_WIDTH(5), .NUM_REGS(32)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_in      (flush_in),
        .commit_en     (commit_en),
        .commit_reg_id (commit_reg_id),
        .commit_data   (commit_data),
        .commit_rob_id (commit_rob_id),
        .rename_en     (rename_en),
        .rename_reg_id (rename_reg_id),
        .rename_rob_id (rename_rob_id),
        .rs1_id        (rs1_id),
        .rs2_id        (rs2_id),
        .rs1_value     (rs1_value),
        .rs1_rob_id    (rs1_rob_id),
        .rs2_value     (rs2_value),
        .rs2_rob_id    (rs2_rob_id)
    );

    always #5 clk_in = ~clk_in;

    // Expected read value given model state and current inputs.
    function automatic logic [31:0] exp_val(input logic [4:0] id);
        if (id == 5'd0) return 32'd0;
`ifdef REG_FILE_COMMIT_BYPASS_EN
        if (rdy_in && commit_en && commit_reg_id == id) return commit_data;
`endif
        return m_val[id];
    endfunction

    function automatic logic [4:0] exp_tag(input logic [4:0] id);
        if (id == 5'd0) return 5'd0;
`ifdef REG_FILE_COMMIT_BYPASS_EN
        if (rdy_in && commit_en && commit_reg_id == id && m_tag[id] == commit_rob_id) return 5'd0;
`endif
        return m_tag[id];
    endfunction

    task automatic idle();
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        commit_en = 1'b0; commit_reg_id = '0; commit_data = '0; commit_rob_id = '0;
        rename_en = 1'b0; rename_reg_id = '0; rename_rob_id = '0;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        logic [31:0] nv [32];
        logic [4:0]  nt [32];
        @(posedge clk_in);
        nv = m_val;
        nt = m_tag;
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin nv[i] = 0; nt[i] = 0; end
        end else if (rdy_in) begin
            if (commit_en && commit_reg_id != 0) begin
                nv[commit_reg_id] = commit_data;
                if (m_tag[commit_reg_id] == commit_rob_id) nt[commit_reg_id] = 0;
            end
            if (rename_en && !flush_in && rename_reg_id != 0) nt[rename_reg_id] = rename_rob_id;
            if (flush_in) for (int i = 0; i < 32; i++) nt[i] = 0;
        end
        m_val = nv;
        m_tag = nt;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_in = 1'b1;
        tick();
        idle();
        rs1_id = 5'd5; rs2_id = 5'd31;
        #1;
        n_tests++; if (rs1_value !== 32'd0) begin n_fail++; $display("FAIL reset_x5_val got %h exp %h", rs1_value, 32'd0); end
        n_tests++; if (rs1_rob_id !== 5'd0) begin n_fail++; $display("FAIL reset_x5_tag got %0d exp %0d", rs1_rob_id, 0); end
        n_tests++; if (rs2_value !== 32'd0) begin n_fail++; $display("FAIL reset_x31_val got %h exp %h", rs2_value, 32'd0); end
        n_tests++; if (rs2_rob_id !== 5'd0) begin n_fail++; $display("FAIL reset_x31_tag got %0d exp %0d", rs2_rob_id, 0); end
        commit_en = 1'b1; commit_reg_id = 5'd0; commit_data = 32'hDEADBEEF; commit_rob_id = 5'd1;
        rs1_id = 5'd0;
        #1;
        n_tests++; if (rs1_value !== 32'd0) begin n_fail++; $display("FAIL x0_bypass_val got %h exp %h", rs1_value, 32'd0); end
        tick();
        idle();
        #1;
        n_tests++; if (rs1_value !== 32'd0) begin n_fail++; $display("FAIL x0_val got %h exp %h", rs1_value, 32'd0); end
        n_tests++; if (rs1_rob_id !== 5'd0) begin n_fail++; $display("FAIL x0_tag got %0d exp %0d", rs1_rob_id, 0); end
    endtask

    task automatic test_rename_commit();
        idle();
        rename_en = 1'b1; rename_reg_id = 5'd3; rename_rob_id = 5'd7;
        rs1_id = 5'd3;
        #1;
        n_tests++; if (rs1_rob_id !== 5'd0) begin n_fail++; $display("FAIL rename_no_bypass got %0d exp %0d", rs1_rob_id, 0); end
        tick();
        idle();
        #1;
        n_tests++; if (rs1_rob_id !== 5'd7) begin n_fail++; $display("FAIL rename_tag got %0d exp %0d", rs1_rob_id, 7); end
        commit_en = 1'b1; commit_reg_id = 5'd3; commit_data = 32'h12345678; commit_rob_id = 5'd7;
        tick();
        idle();
        #1;
        n_tests++; if (rs1_value !== 32'h12345678) begin n_fail++; $display("FAIL commit_val got %h exp %h", rs1_value, 32'h12345678); end
        n_tests++; if (rs1_rob_id !== 5'd0) begin n_fail++; $display("FAIL commit_clear got %0d exp %0d", rs1_rob_id, 0); end
    endtask

    task automatic test_younger_rename();
        idle();
        rename_en = 1'b1; rename_reg_id = 5'd3; rename_rob_id = 5'd7;
        tick();
        rename_rob_id = 5'd9;
        tick();
        idle();
        commit_en = 1'b1; commit_reg_id = 5'd3; commit_data = 32'hAA; commit_rob_id = 5'd7;
        tick();
        idle();
        rs1_id = 5'd3;
        #1;
        n_tests++; if (rs1_value !== 32'hAA) begin n_fail++; $display("FAIL stale_commit_val got %h exp %h", rs1_value, 32'hAA); end
        n_tests++; if (rs1_rob_id !== 5'd9) begin n_fail++; $display("FAIL stale_commit_tag got %0d exp %0d", rs1_rob_id, 9); end
        commit_en = 1'b1; commit_reg_id = 5'd3; commit_data = 32'hBB; commit_rob_id = 5'd9;
        tick();
        tick();
        idle();
        #1;
        n_tests++; if (rs1_value !== 32'hBB) begin n_fail++; $display("FAIL repeat_commit_val got %h exp %h", rs1_value, 32'hBB); end
        n_tests++; if (rs1_rob_id !== 5'd0) begin n_fail++; $display("FAIL repeat_commit_tag got %0d exp %0d", rs1_rob_id, 0); end
    endtask

    task automatic test_same_cycle();
        idle();
        commit_en = 1'b1; commit_reg_id = 5'd4; commit_data = 32'h55; commit_rob_id = 5'd2;
        rename_en = 1'b1; rename_reg_id = 5'd4; rename_rob_id = 5'd6;
        tick();
        idle();
        rs2_id = 5'd4;
        #1;
        n_tests++; if (rs2_value !== 32'h55) begin n_fail++; $display("FAIL same_cycle_val got %h exp %h", rs2_value, 32'h55); end
        n_tests++; if (rs2_rob_id !== 5'd6) begin n_fail++; $display("FAIL same_cycle_tag got %0d exp %0d", rs2_rob_id, 6); end
    endtask

    task automatic test_flush();
        idle();
        rename_en = 1'b1; rename_reg_id = 5'd1; rename_rob_id = 5'd3;
        tick();
        rename_reg_id = 5'd2; rename_rob_id = 5'd4;
        tick();
        idle();
        flush_in = 1'b1;
        rename_en = 1'b1; rename_reg_id = 5'd7; rename_rob_id = 5'd5;
        commit_en = 1'b1; commit_reg_id = 5'd8; commit_data = 32'h11; commit_rob_id = 5'd12;
        tick();
        idle();
        rs1_id = 5'd1; rs2_id = 5'd2;
        #1;
        n_tests++; if (rs1_rob_id !== 5'd0) begin n_fail++; $display("FAIL flush_x1_tag got %0d exp %0d", rs1_rob_id, 0); end
        n_tests++; if (rs2_rob_id !== 5'd0) begin n_fail++; $display("FAIL flush_x2_tag got %0d exp %0d", rs2_rob_id, 0); end
        rs1_id = 5'd7; rs2_id = 5'd8;
        #1;
        n_tests++; if (rs1_rob_id !== 5'd0) begin n_fail++; $display("FAIL flush_x7_tag got %0d exp %0d", rs1_rob_id, 0); end
        n_tests++; if (rs2_value !== 32'h11) begin n_fail++; $display("FAIL flush_x8_val got %h exp %h", rs2_value, 32'h11); end
    endtask

    task automatic test_bypass();
        logic [31:0] old_v;
        idle();
        rename_en = 1'b1; rename_reg_id = 5'd6; rename_rob_id = 5'd10;
        tick();
        idle();
        old_v = m_val[6];
        commit_en = 1'b1; commit_reg_id = 5'd6; commit_data = 32'hCAFE; commit_rob_id = 5'd10;
        rs1_id = 5'd6;
        #1;
`ifdef REG_FILE_COMMIT_BYPASS_EN
        n_tests++; if (rs1_value !== 32'hCAFE) begin n_fail++; $display("FAIL bypass_val got %h exp %h", rs1_value, 32'hCAFE); end
        n_tests++; if (rs1_rob_id !== 5'd0) begin n_fail++; $display("FAIL bypass_tag got %0d exp %0d", rs1_rob_id, 0); end
`else
        n_tests++; if (rs1_value !== old_v) begin n_fail++; $display("FAIL nobypass_val got %h exp %h", rs1_value, old_v); end
        n_tests++; if (rs1_rob_id !== 5'd10) begin n_fail++; $display("FAIL nobypass_tag got %0d exp %0d", rs1_rob_id, 10); end
`endif
        tick();
        idle();
        #1;
        n_tests++; if (rs1_value !== 32'hCAFE) begin n_fail++; $display("FAIL post_commit_val got %h exp %h", rs1_value, 32'hCAFE); end
        n_tests++; if (rs1_rob_id !== 5'd0) begin n_fail++; $display("FAIL post_commit_tag got %0d exp %0d", rs1_rob_id, 0); end
    endtask

    task automatic test_rdy_low();
        logic [31:0] old_v;
        idle();
        rename_en = 1'b1; rename_reg_id = 5'd9; rename_rob_id = 5'd12;
        tick();
        idle();
        old_v = m_val[9];
        rdy_in = 1'b0; flush_in = 1'b1;
        commit_en = 1'b1; commit_reg_id = 5'd9; commit_data = 32'h77; commit_rob_id = 5'd12;
        rename_en = 1'b1; rename_reg_id = 5'd10; rename_rob_id = 5'd3;
        rs1_id = 5'd9; rs2_id = 5'd10;
        #1;
        n_tests++; if (rs1_value !== old_v) begin n_fail++; $display("FAIL rdy_low_live_val got %h exp %h", rs1_value, old_v); end
        tick();
        idle();
        #1;
        n_tests++; if (rs1_value !== old_v) begin n_fail++; $display("FAIL rdy_low_val got %h exp %h", rs1_value, old_v); end
        n_tests++; if (rs1_rob_id !== 5'd12) begin n_fail++; $display("FAIL rdy_low_tag got %0d exp %0d", rs1_rob_id, 12); end
        n_tests++; if (rs2_rob_id !== 5'd0) begin n_fail++; $display("FAIL rdy_low_rename got %0d exp %0d", rs2_rob_id, 0); end
    endtask

    task automatic test_random();
        logic [31:0] ev;
        logic [4:0]  et;
        for (int c = 0; c < 600; c++) begin
            idle();
            rdy_in        = ($urandom_range(0, 9) != 0);
            flush_in      = ($urandom_range(0, 9) == 0);
            commit_en     = $urandom_range(0, 1);
            commit_reg_id = 5'($urandom_range(0, 31));
            commit_data   = $urandom;
            commit_rob_id = $urandom_range(0, 1) ? m_tag[commit_reg_id] : 5'($urandom_range(1, 31));
            rename_en     = $urandom_range(0, 1);
            rename_reg_id = 5'($urandom_range(0, 31));
            rename_rob_id = 5'($urandom_range(1, 31));
            rs1_id        = $urandom_range(0, 2) == 0 ? commit_reg_id : 5'($urandom_range(0, 31));
            rs2_id        = $urandom_range(0, 2) == 0 ? rename_reg_id : 5'($urandom_range(0, 31));
            #1;
            ev = exp_val(rs1_id); et = exp_tag(rs1_id);
            n_tests++; if (rs1_value !== ev) begin n_fail++; $display("FAIL rand_rs1_val c=%0d x%0d got %h exp %h", c, rs1_id, rs1_value, ev); end
            n_tests++; if (rs1_rob_id !== et) begin n_fail++; $display("FAIL rand_rs1_tag c=%0d x%0d got %0d exp %0d", c, rs1_id, rs1_rob_id, et); end
            ev = exp_val(rs2_id); et = exp_tag(rs2_id);
            n_tests++; if (rs2_value !== ev) begin n_fail++; $display("FAIL rand_rs2_val c=%0d x%0d got %h exp %h", c, rs2_id, rs2_value, ev); end
            n_tests++; if (rs2_rob_id !== et) begin n_fail++; $display("FAIL rand_rs2_tag c=%0d x%0d got %0d exp %0d", c, rs2_id, rs2_rob_id, et); end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_tag[i] = 0; end
        idle();
        rs1_id = '0; rs2_id = '0;
        test_reset();
        test_rename_commit();
        test_younger_rename();
        test_same_cycle();
        test_flush();
        test_bypass();
        test_rdy_low();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
